// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Four-requester round-robin arbiter feeding one synchronous
//                FIFO write port. A burst is only granted when the FIFO has
//                room for a full BURST_MAX words, so a granted burst never
//                waits on space. Bursts end on last, on BURST_MAX words, or
//                when the owner drops its request.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH     = 8,
    parameter int LOG_FIFO_DEPTH = 4,
    parameter int BURST_MAX      = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [3:0]                  i_req,
    input  logic [4*FIFO_WIDTH-1:0]     i_data,
    input  logic [3:0]                  i_last,
    input  logic                        i_fifo_full,
    input  logic [LOG_FIFO_DEPTH:0]     i_fifo_entries,
    output logic [3:0]                  o_gnt,
    output logic [3:0]                  o_ack,
    output logic                        o_fifo_wr,
    output logic [FIFO_WIDTH-1:0]       o_fifo_data,
    output logic [1:0]                  o_owner,
    output logic                        o_stall
);

    // Beat counter must be able to hold BURST_MAX itself, hence the extra bit.
    localparam int BEAT_W = $clog2(BURST_MAX) + 1;

    localparam logic [LOG_FIFO_DEPTH:0] C_DEPTH     = (LOG_FIFO_DEPTH+1)'(1 << LOG_FIFO_DEPTH);
    localparam logic [LOG_FIFO_DEPTH:0] C_BURST_MAX = (LOG_FIFO_DEPTH+1)'(BURST_MAX);
    localparam logic [BEAT_W-1:0]       C_BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_gnt;
    logic [3:0]            w_gnt_nxt;
    logic [1:0]            r_owner;
    logic [1:0]            w_owner_nxt;
    logic [BEAT_W-1:0]     r_beat;
    logic [BEAT_W-1:0]     w_beat_nxt;
    logic [1:0]            r_ptr;
    logic [1:0]            w_ptr_nxt;

    logic [LOG_FIFO_DEPTH:0] w_free;
    logic                    w_space_ok;
    logic                    w_any_req;
    logic [1:0]              w_win;
    logic                    w_win_vld;
    logic                    w_accept;
    logic                    w_owner_req;
    logic                    w_owner_last;
    logic                    w_burst_end;
    logic                    w_stall;

    // Free-space and request summary used by the IDLE grant decision.
    assign w_free       = C_DEPTH - i_fifo_entries;
    assign w_space_ok   = (w_free >= C_BURST_MAX);
    assign w_any_req    = |i_req;
    assign w_owner_req  = i_req[r_owner];
    assign w_owner_last = i_last[r_owner];

    // Cyclic search for the next requester, starting just after the pointer.
    always_comb begin
        w_win     = 2'd0;
        w_win_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_win_vld && i_req[r_ptr + 2'(i)]) begin
                w_win     = r_ptr + 2'(i);
                w_win_vld = 1'b1;
            end
        end
    end

    // Next-state, accept and stall decode for the two-state burst machine.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat;
        w_ptr_nxt   = r_ptr;
        w_accept    = 1'b0;
        w_burst_end = 1'b0;
        w_stall     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    if (w_space_ok && w_win_vld) begin
                        w_state_nxt = BURST;
                        w_gnt_nxt   = 4'b0001 << w_win;
                        w_owner_nxt = w_win;
                        w_ptr_nxt   = w_win;
                        w_beat_nxt  = '0;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            BURST: begin
                // Full gating is kept even though a granted burst should
                // always fit; a second writer could still fill the FIFO.
                w_accept = w_owner_req && !i_fifo_full;
                if (w_accept) begin
                    w_beat_nxt  = r_beat + 1'b1;
                    w_burst_end = w_owner_last || (r_beat == C_BEAT_LAST);
                end
                if (w_burst_end || !w_owner_req) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = 4'b0000;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State, grant, owner, beat counter and round-robin pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_owner <= 2'd0;
            r_beat  <= '0;
            r_ptr   <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_beat  <= w_beat_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_owner     = r_owner;
    assign o_fifo_wr   = w_accept;
    assign o_ack       = w_accept ? (4'b0001 << r_owner) : 4'b0000;
    assign o_fifo_data = i_data[r_owner*FIFO_WIDTH +: FIFO_WIDTH];
    assign o_stall     = w_stall;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001 Parameter FIFO_WIDTH, 8, word width of each requester and of the FIFO write port SHALL be this value.
- REQ-002 Parameter LOG_FIFO_DEPTH, 4, log2 of the downstream sfifo depth SHALL be this value.
- REQ-003 Parameter BURST_MAX, 4, maximum words per grant SHALL be this value, with legal range 1..2^LOG_FIFO_DEPTH.
- REQ-004 i_clk  in  1  The block SHALL use this single clock, with all state updating on the rising edge.
- REQ-005 i_reset  in  1  The block SHALL use this as its reset, which is synchronous and active-high.
- REQ-006 i_req  in  4  Per-requester word-valid; bit k SHALL mean requester k has a word presented.
- REQ-007 i_data  in  4*FIFO_WIDTH  Requester k's word SHALL be carried on bits [k*FIFO_WIDTH +: FIFO_WIDTH].
- REQ-008 i_last  in  4  Bit k high SHALL mark requester k's current word as the last word of its burst.
- REQ-009 i_fifo_full  in  1  This input SHALL carry sfifo o_full.
- REQ-010 i_fifo_entries  in  LOG_FIFO_DEPTH+1  This input SHALL carry sfifo o_entries.
- REQ-011 o_gnt  out  4  This output SHALL be the registered one-hot grant, all-zero when no burst is owned.
- REQ-012 o_ack  out  4  Bit k SHALL pulse for one cycle per word accepted from requester k.
- REQ-013 o_fifo_wr  out  1  This output SHALL drive sfifo i_wr.
- REQ-014 o_fifo_data  out  FIFO_WIDTH  This output SHALL drive sfifo i_data.
- REQ-015 o_owner  out  2  This output SHALL give the index of the current or most recent grantee.
- REQ-016 o_stall  out  1  This output SHALL be high while in IDLE when requests are pending but FIFO space is insufficient.

Function
- REQ-017 The state machine SHALL have exactly two states, IDLE and BURST, with state, o_gnt, o_owner, the beat counter and the round-robin pointer all registered.
- REQ-018 Free space SHALL be computed as (1<<LOG_FIFO_DEPTH) - i_fifo_entries, at LOG_FIFO_DEPTH+1 bits, unsigned.
- REQ-019 In IDLE, when |i_req and free >= BURST_MAX, the block SHALL go to BURST on the next edge and grant the first requesting index searched cyclically from pointer+1.
- REQ-020 On the IDLE-to-BURST transition, o_gnt SHALL be set one-hot, o_owner and pointer SHALL be set to the winner, and the beat counter SHALL be set to 0.
- REQ-021 In IDLE, when |i_req and free < BURST_MAX, the block SHALL stay in IDLE, hold o_gnt at 0 and drive o_stall to 1 combinationally.
- REQ-022 In BURST, accept SHALL equal i_req[o_owner] && !i_fifo_full.
- REQ-023 o_fifo_wr SHALL equal accept, and o_ack SHALL equal accept shifted to bit o_owner; both are combinational.
- REQ-024 o_fifo_data SHALL equal the o_owner slice of i_data, combinationally and at all times.
- REQ-025 Each accept SHALL increment the beat counter, which is clog2(BURST_MAX)+1 bits wide.
- REQ-026 The burst SHALL end on an accept with i_last[o_owner]=1, or on an accept with beat counter = BURST_MAX-1.
- REQ-027 When the burst ends, the next state SHALL be IDLE with o_gnt cleared, and o_owner SHALL be held.
- REQ-028 In BURST with i_req[o_owner]=0, there SHALL be no accept, and the next state SHALL be IDLE (owner release).
- REQ-029 Exactly one cycle SHALL separate consecutive bursts, because IDLE is always visited.
- REQ-030 Requests from non-owners during BURST SHALL be ignored and SHALL never be acked.
- REQ-031 The pointer SHALL wrap from 3 to 0, and the cyclic search SHALL wrap modulo 4.
- REQ-032 Given free >= BURST_MAX at grant and a sole writer, i_fifo_full SHALL not rise mid-burst; the accept gating SHALL remain regardless.
- REQ-033 o_fifo_wr SHALL be 0 in IDLE.

Reset
- REQ-034 When i_reset=1 at an edge, the block SHALL set state to IDLE, o_gnt to 0, o_owner to 0, the beat counter to 0 and the pointer to 3, so that requester 0 has first priority.
- REQ-035 Reset asserted mid-burst SHALL abort the burst on that edge, with no further accepts, and o_fifo_wr and o_ack SHALL be 0 in the following cycle.
- REQ-036 Reset SHALL take priority over all other transitions.

Verification
- REQ-037 Scenario (reset default): after reset, i_req=4'b1111, i_fifo_entries=0 -> next cycle o_gnt=0001; four accepts with o_ack=0001; then IDLE one cycle; then o_gnt=0010.
- REQ-038 Scenario (early last): owner 2, i_last asserted on the 2nd accepted word -> exactly 2 o_fifo_wr pulses; o_gnt=0 next cycle; o_owner=2 held.
- REQ-039 Scenario (space stall): i_fifo_entries=13, BURST_MAX=4, i_req=0100 -> o_stall=1, o_gnt=0; entries drop to 12 -> o_gnt=0100 next cycle.
- REQ-040 Scenario (owner release): owner 1 drops i_req after 1 accept -> BURST exits next edge with no ack in the drop cycle; pending requester 3 is granted after the IDLE cycle.
- REQ-041 Scenario (full gating): force i_fifo_full=1 for 2 cycles in BURST -> o_fifo_wr=0 and o_ack=0 in those cycles; beat counter unchanged; burst resumes afterwards.
- REQ-042 Scenario (reset mid-burst): i_reset pulsed after 2 accepts -> o_gnt=0, state IDLE, pointer=3; the next grant goes to the lowest requesting index.
